// File: rtl/sll_iter_pkg.sv
// Shared definitions for the iterative left shifter: state encoding and the
// default datapath sizes used across the logic units.
package sll_iter_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SHW   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/sll_step.sv
// Combinational left shift of WIDTH bits by 0..STEP positions, zero-filled from
// the LSB. amt values above STEP select the unshifted operand.
module sll_step #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int AW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [AW-1:0]    amt,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] cand [STEP+1];

    generate
        for (genvar gi = 0; gi <= STEP; gi++) begin : g_cand
            assign cand[gi] = a << gi;
        end
    endgenerate

    always_comb begin
        y = cand[0];
        for (int i = 1; i <= STEP; i++) begin
            if (amt == AW'(i)) begin
                y = cand[i];
            end
        end
    end

endmodule

// File: rtl/sll_iter.sv
// Multi-cycle logical left shifter: accepts an operand over valid/ready, shifts
// it up to STEP bits per cycle, then holds the result until it is consumed.
module sll_iter
    import sll_iter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Ain,
    input  logic [SHW-1:0]   shamt,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Aout,
    output logic             busy
);

    localparam int             AW     = $clog2(STEP + 1);
    localparam logic [SHW:0]   STEP_C = (SHW + 1)'(STEP);

    generate
        if (!(STEP == 1 || STEP == 2 || STEP == 4)) begin : g_bad_step
            $error("sll_iter: STEP must be 1, 2 or 4");
        end
        if (SHW < AW) begin : g_bad_shw
            $error("sll_iter: SHW too narrow for the chosen STEP");
        end
    endgenerate

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   acc_reg, acc_next;
    logic [SHW-1:0]     cnt_reg, cnt_next;
    logic [WIDTH-1:0]   step_y;
    logic [AW-1:0]      amt;
    logic               last;

    // Final iteration shifts by whatever remains (possibly 0 when shamt=0).
    assign last = ({1'b0, cnt_reg} <= STEP_C);
    assign amt  = last ? cnt_reg[AW-1:0] : AW'(STEP);

    sll_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .AW    (AW)
    ) u_step (
        .a   (acc_reg),
        .amt (amt),
        .y   (step_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        acc_next   = Ain;
                        cnt_next   = shamt;
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    acc_next = step_y;
                    if (last) begin
                        cnt_next   = '0;
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt_reg - STEP_C[SHW-1:0];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign Aout      = acc_reg;

endmodule

// File: doc/sll_iter.md
Name: sll_iter

Overview:
Multi-cycle 16-bit logical left shifter. It is the left-direction companion to the single-cycle logical right shifter in logunits. Operands are accepted over a valid/ready handshake and shifted STEP bits per cycle, so area stays small. The result is held on an output valid/ready handshake until the consumer accepts it. It serves the ALU/shift path wherever a registered, area-cheap SLL is acceptable.

Parameters:
WIDTH, 16, datapath width in bits
SHW, 4, shift-amount width; legal shamt range is 0..2^SHW-1
STEP, 1, maximum bits shifted per cycle; legal values are 1, 2, 4

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand valid
in_ready  output  1  block can accept an operand
Ain  input  WIDTH  operand to shift
shamt  input  SHW  shift amount
flush  input  1  synchronous abort; discards any in-flight or held result
out_valid  output  1  Aout holds a valid result
out_ready  input  1  consumer accepts the result
Aout  output  WIDTH  shifted result; zero-filled from the LSB
busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, acc=0, cnt=0.
  - in_ready=1, out_valid=0, busy=0, Aout=0.
  - Reset asserted mid-shift or mid-hold aborts the operation with no partial result.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept when in_valid && in_ready at an edge (the accept edge). Load acc=Ain, cnt=shamt, go to SHIFT.
  - Ain and shamt are sampled only at the accept edge; later changes are ignored.
- SHIFT, evaluated each edge:
  - If cnt <= STEP: acc <= acc << cnt, cnt <= 0, go to DONE.
  - Else: acc <= acc << STEP, cnt <= cnt - STEP, stay in SHIFT.
  - in_ready=0, out_valid=0.
- DONE:
  - out_valid=1, Aout=acc, in_ready=0.
  - Aout is held stable while out_valid && !out_ready.
  - On out_ready: go to IDLE.
  - No same-cycle re-accept; a new operand is accepted at the earliest one cycle after the result handshake.
- Latency:
  - out_valid rises n edges after the accept edge, where n = max(1, ceil(shamt/STEP)).
  - Examples: shamt=0 gives 1 cycle; STEP=1, shamt=15 gives 15 cycles; STEP=4, shamt=15 gives 4 cycles.
- Arithmetic: logical shift with zeros into the LSB; bits shifted past the MSB are lost. Result must equal (Ain << shamt) truncated to WIDTH.
- Aout outside DONE: drives acc. Consumers must qualify Aout with out_valid.
- flush:
  - In any state, forces IDLE at the next edge with out_valid=0. acc and cnt are don't-care.
  - flush takes priority over an in_valid accept in the same cycle; that operand is not accepted.
  - flush takes priority over out_ready in DONE; the result is dropped.
- busy = (state != IDLE).
- Invalid STEP values are rejected by an elaboration-time check. The state encoding has no illegal-state recovery requirement beyond the default going to IDLE.

Decomposition:
- Shared package/include: state encodings (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the default WIDTH/SHW values shared with the other logunits.
- One sub-module, sll_step: a combinational left shift of WIDTH bits by 0..STEP, instantiated once to feed acc.
- Counter, FSM and handshake logic stay in sll_iter.

Test Plan:
- STEP=1, Ain=16'h0001, shamt=15, out_ready=1 -> out_valid high exactly 15 cycles after accept, Aout=16'h8000, in_ready low throughout.
- STEP=1, Ain=16'hA5A5, shamt=0 -> out_valid 1 cycle after accept, Aout=16'hA5A5; Ain=16'hFFFF, shamt=4 -> Aout=16'hFFF0 after 4 cycles.
- STEP=4, Ain=16'h1234, shamt=9 -> out_valid after 3 cycles, Aout=16'h6800; shamt=15 -> 4 cycles, Aout=16'h0000.
- Backpressure: result ready, out_ready low for 5 cycles -> Aout stable, out_valid held, in_ready=0; out_ready high -> IDLE next edge, in_ready=1. Drive Ain changes during SHIFT -> result unaffected.
- flush asserted on cycle 3 of a shamt=10 shift -> IDLE next edge, no out_valid pulse. flush with in_valid in IDLE -> no accept. flush in DONE with out_ready=1 -> result dropped.
- rst_n pulsed low asynchronously mid-SHIFT -> outputs go to reset values immediately; after release, a fresh op Ain=16'h00FF, shamt=8 yields 16'hFF00. Follow with a random sweep of all 16 shamt values × 1000 Ain values per legal STEP, checked against Ain<<shamt.
